// File: rtl/compare_sequencer.sv
// Serial MSB-first magnitude comparator driving a comparison-symbol decoder.
// Produces =, >, < codes with a one-cycle done pulse and optional timed blanking.
module compare_sequencer #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [2:0]       symbol
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HC_W  = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MSB   = IDX_W'(WIDTH - 1);
  localparam logic [HC_W-1:0]  HOLD_ONE  = HC_W'(1);
  localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYCLES);

  localparam logic [2:0] SYM_BLANK = 3'b000;
  localparam logic [2:0] SYM_EQ    = 3'b100;
  localparam logic [2:0] SYM_GT    = 3'b010;
  localparam logic [2:0] SYM_LT    = 3'b001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       symbol_q, symbol_d;

  // Next-state and next-output computation for the comparison sequencer.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    symbol_d = symbol_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          idx_d    = IDX_MSB;
          busy_d   = 1'b1;
          symbol_d = SYM_BLANK;
          state_d  = COMPARE;
        end else begin
          busy_d   = 1'b0;
          symbol_d = SYM_BLANK;
        end
      end
      COMPARE: begin
        // Only the shadow operands are examined; start and live inputs are ignored here.
        if (a_q[idx_q] != b_q[idx_q]) begin
          symbol_d = a_q[idx_q] ? SYM_GT : SYM_LT;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          hold_d   = HOLD_LOAD;
          state_d  = HOLD;
        end else if (idx_q == '0) begin
          symbol_d = SYM_EQ;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          hold_d   = HOLD_LOAD;
          state_d  = HOLD;
        end else begin
          idx_d    = idx_q - IDX_ONE;
        end
      end
      HOLD: begin
        // A new start takes priority over a hold expiry landing on the same edge.
        if (start) begin
          a_d      = a;
          b_d      = b;
          idx_d    = IDX_MSB;
          busy_d   = 1'b1;
          symbol_d = SYM_BLANK;
          state_d  = COMPARE;
        end else if ((HOLD_CYCLES != 0) && (hold_q == HOLD_ONE)) begin
          hold_d   = '0;
          symbol_d = SYM_BLANK;
          state_d  = IDLE;
        end else if (HOLD_CYCLES != 0) begin
          hold_d   = hold_q - HOLD_ONE;
        end else begin
          hold_d   = hold_q;
        end
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        symbol_d = SYM_BLANK;
      end
    endcase
  end

  // State, shadow operand and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      symbol_q <= SYM_BLANK;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      symbol_q <= symbol_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign symbol = symbol_q;

endmodule

// File: tb/tb_compare_sequencer.sv
// Bench for compare_sequencer: a vector table plus hand-written corner sequences,
// with results predicted into a scoreboard queue and checked when done pulses.
module tb_compare_sequencer;

  logic       clk, rst_n, start;
  logic [7:0] a, b;
  logic       busy0, done0, busy4, done4;
  logic [2:0] sym0, sym4;

  compare_sequencer #(.WIDTH(8), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .symbol(sym0)
  );

  compare_sequencer #(.WIDTH(8), .HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy4), .done(done4), .symbol(sym4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sym;
    int         lat;
  } vec_t;

  typedef struct {
    logic [2:0] sym;
    int         exp_cyc;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest predicted result.
  task automatic sb_check();
    sb_t e;
    if (done4 !== done0) chk("done_match", {31'd0, done4}, {31'd0, done0});
    if (done0) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result_sym", {29'd0, sym0}, {29'd0, e.sym});
        chk("result_sym_h4", {29'd0, sym4}, {29'd0, e.sym});
        chk("result_cycle", cyc, e.exp_cyc);
        chk("busy_at_done", {31'd0, busy0}, 32'd0);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_check();
  endtask

  task automatic wait_sb();
    int n = 0;
    while (sb.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic [7:0] va, input logic [7:0] vb,
                       input logic [2:0] s, input int lat);
    sb_t e;
    a = va;
    b = vb;
    start = 1'b1;
    e.sym = s;
    e.exp_cyc = cyc + 1 + lat;
    sb.push_back(e);
  endtask

  task automatic reset_check(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_busy"}, {30'd0, busy0, busy4}, 32'd0);
    chk({tag, "_done"}, {30'd0, done0, done4}, 32'd0);
    chk({tag, "_sym"},  {26'd0, sym0, sym4}, 32'd0);
    sb.delete();
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 3'b100, 8};
    vecs[1] = '{8'h80, 8'h7F, 3'b010, 1};
    vecs[2] = '{8'h12, 8'h13, 3'b001, 8};
    vecs[3] = '{8'h01, 8'h00, 3'b010, 8};
    vecs[4] = '{8'h00, 8'h00, 3'b100, 8};
    vecs[5] = '{8'hFF, 8'h00, 3'b010, 1};
    vecs[6] = '{8'h40, 8'h60, 3'b001, 3};
    vecs[7] = '{8'hC3, 8'hC1, 3'b010, 7};

    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (2) tick();
    chk("reset_busy", {30'd0, busy0, busy4}, 32'd0);
    chk("reset_done", {30'd0, done0, done4}, 32'd0);
    chk("reset_sym",  {26'd0, sym0, sym4}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table: result/latency via scoreboard, then hold and blanking behaviour.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sym, vecs[i].lat);
      tick();
      start = 1'b0;
      chk("busy_after_start", {30'd0, busy0, busy4}, 32'd3);
      chk("blank_after_start", {26'd0, sym0, sym4}, 32'd0);
      wait_sb();
      repeat (3) tick();
      chk("h4_still_held", {29'd0, sym4}, {29'd0, vecs[i].sym});
      tick();
      chk("h4_blanked", {29'd0, sym4}, 32'd0);
      chk("h0_still_held", {29'd0, sym0}, {29'd0, vecs[i].sym});
      chk("idle_busy", {30'd0, busy0, busy4}, 32'd0);
    end

    // Inputs changed and start pulsed mid-compare must not disturb the result.
    issue(8'h12, 8'h13, 3'b001, 8);
    tick();
    start = 1'b0;
    repeat (2) tick();
    a = 8'hFF;
    b = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_sb();
    repeat (2) tick();
    chk("midstart_ignored_busy", {30'd0, busy0, busy4}, 32'd0);

    // Start on the same edge as hold expiry restarts cleanly.
    issue(8'h01, 8'h00, 3'b010, 8);
    tick();
    start = 1'b0;
    wait_sb();
    repeat (3) tick();
    issue(8'h80, 8'h7F, 3'b010, 1);
    tick();
    start = 1'b0;
    chk("expiry_start_busy", {31'd0, busy4}, 32'd1);
    chk("expiry_start_sym", {29'd0, sym4}, 32'd0);
    wait_sb();

    // Start held high: back-to-back compares every 9 cycles.
    begin
      int m;
      m = cyc;
      issue(8'h00, 8'h00, 3'b100, 8);
      begin
        sb_t e;
        e.sym = 3'b100; e.exp_cyc = m + 18; sb.push_back(e);
        e.sym = 3'b100; e.exp_cyc = m + 27; sb.push_back(e);
      end
      for (int k = 0; k < 27; k++) begin
        tick();
        if (cyc == m + 10) begin
          chk("b2b_recapture_sym", {29'd0, sym0}, 32'd0);
          chk("b2b_recapture_busy", {31'd0, busy0}, 32'd1);
        end
      end
      start = 1'b0;
      chk("b2b_all_done", sb.size(), 32'd0);
    end

    // Reset while holding a result blanks the symbol asynchronously.
    reset_check("rst_hold");
    tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-compare aborts with no later done.
    issue(8'h12, 8'h13, 3'b001, 8);
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset_check("rst_cmp");
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("post_reset_idle_busy", {30'd0, busy0, busy4}, 32'd0);
    chk("post_reset_idle_sym", {26'd0, sym0, sym4}, 32'd0);

    issue(8'h80, 8'h7F, 3'b010, 1);
    tick();
    start = 1'b0;
    wait_sb();
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
